bomb_placer: RTL and testbench
==============================

// Module: bomb_placer
// PURPOSE
//  Consumes the player position produced by the player motion stage and the drop_bomb key.
//  On a drop request it snaps the player centre to the 32x32 play-field tile grid and arms a bomb on that tile.
//  It counts the fuse in frames, then drives an explosion window and a cooldown before it accepts the next bomb.
//  Its outputs feed the bomb/blast drawing objects and collision logic. One bomb is live at a time.
// PARAMETERS
//  FUSE_FRAMES     90  frames from arming to explosion (3 s at 30 Hz)
//  BLAST_FRAMES    15  frames the explosion stays asserted
//  COOLDOWN_FRAMES  6  frames after the blast before a new drop is accepted
//  TILE_SIZE       32  tile edge in pixels, power of 2
//  FRAME_LEFT      16  pixel X of play-field column 0
//  FRAME_TOP       48  pixel Y of play-field row 0
//  NUM_COLS        19  play-field columns
//  NUM_ROWS        13  play-field rows
// PORTS
//  clk              in   1   system clock
//  resetN           in   1   synchronous active-low reset
//  startOfFrame     in   1   one-clk pulse per frame (30 Hz)
//  drop_bomb        in   1   drop key, level
//  detonate         in   1   one-clk pulse: chain-hit by another blast, forces early explosion
//  playerTopLeftX   in   11  signed player top-left X (pixels)
//  playerTopLeftY   in   11  signed player top-left Y (pixels)
//  bomb_active      out  1   bomb armed and not yet exploded
//  exploding        out  1   blast window active
//  bombTopLeftX     out  11  signed bomb tile top-left X
//  bombTopLeftY     out  11  signed bomb tile top-left Y
//  bombCol          out  5   bomb tile column, 0..NUM_COLS-1
//  bombRow          out  4   bomb tile row, 0..NUM_ROWS-1
//  fuseLeft         out  8   frames remaining in the current ARMED/BLAST/COOLDOWN phase
// BEHAVIOUR
//  Reset (resetN=0 at posedge clk): state=IDLE_ST; all outputs 0; drop edge register cleared.
//  The block registers drop_bomb every clk. dropEdge = drop_bomb & ~drop_bomb_d. A held key arms at most once.
//  Snap, combinational from the inputs:
//   cx = X+TILE_SIZE/2 and cy = Y+TILE_SIZE/2, in 12-bit signed arithmetic.
//   col = (cx-FRAME_LEFT)>>>5, clamped to 0..NUM_COLS-1. A negative value clamps to 0.
//   row = (cy-FRAME_TOP)>>>5, clamped to 0..NUM_ROWS-1.
//   bombTopLeftX = FRAME_LEFT+col*TILE_SIZE. bombTopLeftY = FRAME_TOP+row*TILE_SIZE.
//  States:
//   IDLE_ST: on dropEdge, latch col/row/bombTopLeft* and load fuseLeft=FUSE_FRAMES.
//     bomb_active=1 on the next clk (1-clk latency). Go to ARMED_ST.
//   ARMED_ST:
//     Each startOfFrame decrements fuseLeft.
//     On the startOfFrame where fuseLeft==1, or on detonate (detonate has priority when both occur in one clk):
//     bomb_active=0, exploding=1, fuseLeft=BLAST_FRAMES, go to BLAST_ST.
//   BLAST_ST: startOfFrame decrements fuseLeft. At 1: exploding=0, fuseLeft=COOLDOWN_FRAMES, go to COOL_ST.
//   COOL_ST: startOfFrame decrements fuseLeft. At 1: fuseLeft=0, go to IDLE_ST.
//  The latched position is held until the next arming. bombTopLeft*/bombCol/bombRow stay valid through BLAST_ST.
//  Drops outside IDLE_ST are ignored and never queued. detonate outside ARMED_ST is ignored.
//  A drop edge in the same clk as the COOL_ST->IDLE_ST transition is ignored.
//  Player motion never moves a latched bomb.
//  Any phase count of 0 is treated as 1 (minimum one frame).
//  A reset mid-phase aborts immediately to IDLE_ST with all outputs 0. No explosion is emitted.
//  Outputs are registered, except that fuseLeft is the live counter.
// TESTING
//  1 Player (280,185), drop pulse -> 1 clk later bomb_active=1, col=8, row=4, bombTopLeft=(272,176), fuseLeft=90.
//  2 Armed bomb, 90 startOfFrame pulses -> at pulse 90 exploding=1 and bomb_active=0.
//    15 frames later exploding=0. 6 frames later the block returns to IDLE_ST.
//  3 Player (-20,600), drop -> clamps to col=0, row=12, bombTopLeft=(16,432).
//  4 Hold drop_bomb high through a full cycle back to IDLE_ST -> no re-arm until the key is released and pressed again.
//  5 detonate at fuse frame 40, coincident with startOfFrame -> exploding=1 next clk, fuseLeft=15.
//  6 resetN=0 mid-BLAST_ST -> next clk all outputs 0. A drop right after reset arms normally.

Source files
------------

// File: rtl/bomb_placer.sv
// bomb_placer: snaps the player centre to the tile grid, arms one bomb, then runs fuse, blast and cooldown phases.
module bomb_placer #(
    parameter int FUSE_FRAMES     = 90,
    parameter int BLAST_FRAMES    = 15,
    parameter int COOLDOWN_FRAMES = 6,
    parameter int TILE_SIZE       = 32,
    parameter int FRAME_LEFT      = 16,
    parameter int FRAME_TOP       = 48,
    parameter int NUM_COLS        = 19,
    parameter int NUM_ROWS        = 13
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        drop_bomb,
    input  logic        detonate,
    input  logic [10:0] playerTopLeftX,
    input  logic [10:0] playerTopLeftY,
    output logic        bomb_active,
    output logic        exploding,
    output logic [10:0] bombTopLeftX,
    output logic [10:0] bombTopLeftY,
    output logic [4:0]  bombCol,
    output logic [3:0]  bombRow,
    output logic [7:0]  fuseLeft
);
    typedef enum logic [1:0] {IDLE_ST, ARMED_ST, BLAST_ST, COOL_ST} state_t;
    localparam int SH = $clog2(TILE_SIZE);
    localparam logic [7:0] FUSE  = 8'(FUSE_FRAMES     == 0 ? 1 : FUSE_FRAMES);
    localparam logic [7:0] BLAST = 8'(BLAST_FRAMES    == 0 ? 1 : BLAST_FRAMES);
    localparam logic [7:0] COOL  = 8'(COOLDOWN_FRAMES == 0 ? 1 : COOLDOWN_FRAMES);
    state_t state, state_n;
    logic drop_d, drop_edge, active_n, expl_n, last;
    logic [7:0] fuse_n;
    logic [10:0] tlx_n, tly_n, tlx_c, tly_c;
    logic [4:0] col_n, col_c;
    logic [3:0] row_n, row_c;
    logic signed [11:0] cx, cy, col_raw, row_raw;
    assign drop_edge = drop_bomb & ~drop_d;
    assign cx = $signed({playerTopLeftX[10], playerTopLeftX}) + $signed(12'(TILE_SIZE / 2 - FRAME_LEFT));
    assign cy = $signed({playerTopLeftY[10], playerTopLeftY}) + $signed(12'(TILE_SIZE / 2 - FRAME_TOP));
    assign col_raw = cx >>> SH;
    assign row_raw = cy >>> SH;
    assign col_c = col_raw < 12'sd0 ? 5'd0 : col_raw > $signed(12'(NUM_COLS - 1)) ? 5'(NUM_COLS - 1) : col_raw[4:0];
    assign row_c = row_raw < 12'sd0 ? 4'd0 : row_raw > $signed(12'(NUM_ROWS - 1)) ? 4'(NUM_ROWS - 1) : row_raw[3:0];
    assign tlx_c = 11'(FRAME_LEFT) + 11'(col_c) * 11'(TILE_SIZE);
    assign tly_c = 11'(FRAME_TOP) + 11'(row_c) * 11'(TILE_SIZE);
    // a zero count would otherwise wrap, so <=1 ends the phase
    assign last = startOfFrame && fuseLeft <= 8'd1;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state        <= IDLE_ST;
            drop_d       <= 1'b0;
            bomb_active  <= 1'b0;
            exploding    <= 1'b0;
            fuseLeft     <= 8'd0;
            bombTopLeftX <= 11'd0;
            bombTopLeftY <= 11'd0;
            bombCol      <= 5'd0;
            bombRow      <= 4'd0;
        end else begin
            state        <= state_n;
            drop_d       <= drop_bomb;
            bomb_active  <= active_n;
            exploding    <= expl_n;
            fuseLeft     <= fuse_n;
            bombTopLeftX <= tlx_n;
            bombTopLeftY <= tly_n;
            bombCol      <= col_n;
            bombRow      <= row_n;
        end
    end

    always_comb begin
        state_n  = state;
        active_n = bomb_active;
        expl_n   = exploding;
        fuse_n   = fuseLeft;
        tlx_n    = bombTopLeftX;
        tly_n    = bombTopLeftY;
        col_n    = bombCol;
        row_n    = bombRow;
        case (state)
            IDLE_ST: if (drop_edge) begin
                state_n  = ARMED_ST;
                active_n = 1'b1;
                fuse_n   = FUSE;
                tlx_n    = tlx_c;
                tly_n    = tly_c;
                col_n    = col_c;
                row_n    = row_c;
            end
            ARMED_ST: if (detonate || last) begin
                state_n  = BLAST_ST;
                active_n = 1'b0;
                expl_n   = 1'b1;
                fuse_n   = BLAST;
            end else if (startOfFrame) fuse_n = fuseLeft - 8'd1;
            BLAST_ST: if (last) begin
                state_n = COOL_ST;
                expl_n  = 1'b0;
                fuse_n  = COOL;
            end else if (startOfFrame) fuse_n = fuseLeft - 8'd1;
            default: if (last) begin
                state_n = IDLE_ST;
                fuse_n  = 8'd0;
            end else if (startOfFrame) fuse_n = fuseLeft - 8'd1;
        endcase
    end
endmodule

// File: tb/tb_bomb_placer.sv
// tb_bomb_placer: directed vectors with hand-computed expectations for bomb_placer.
module tb_bomb_placer;
    logic clk = 1'b0, resetN, startOfFrame, drop_bomb, detonate;
    logic [10:0] playerTopLeftX, playerTopLeftY, bombTopLeftX, bombTopLeftY;
    logic bomb_active, exploding;
    logic [4:0] bombCol;
    logic [3:0] bombRow;
    logic [7:0] fuseLeft;
    int n_chk = 0, n_err = 0;

    bomb_placer dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .drop_bomb(drop_bomb),
        .detonate(detonate), .playerTopLeftX(playerTopLeftX), .playerTopLeftY(playerTopLeftY),
        .bomb_active(bomb_active), .exploding(exploding), .bombTopLeftX(bombTopLeftX),
        .bombTopLeftY(bombTopLeftY), .bombCol(bombCol), .bombRow(bombRow), .fuseLeft(fuseLeft)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic drop_pulse();
        drop_bomb = 1'b1;
        tick();
        drop_bomb = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic a, input logic e, input logic [7:0] f);
        chk({tag, ".active"}, 32'(bomb_active), 32'(a));
        chk({tag, ".expl"}, 32'(exploding), 32'(e));
        chk({tag, ".fuse"}, 32'(fuseLeft), 32'(f));
    endtask

    task automatic chk_pos(input string tag, input int c, input int r, input int x, input int y);
        chk({tag, ".col"}, 32'(bombCol), 32'(c));
        chk({tag, ".row"}, 32'(bombRow), 32'(r));
        chk({tag, ".x"}, 32'(bombTopLeftX), 32'(x));
        chk({tag, ".y"}, 32'(bombTopLeftY), 32'(y));
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; drop_bomb = 1'b0; detonate = 1'b0;
        playerTopLeftX = 11'd280; playerTopLeftY = 11'd185;
        tick(); tick();
        chk_all("reset", 1'b0, 1'b0, 8'd0);
        chk_pos("reset", 0, 0, 0, 0);
        resetN = 1'b1;
        tick();
        chk_all("idle", 1'b0, 1'b0, 8'd0);

        drop_pulse();
        chk_all("arm1", 1'b1, 1'b0, 8'd90);
        chk_pos("arm1", 8, 4, 272, 176);

        repeat (89) frame();
        chk_all("fuse89", 1'b1, 1'b0, 8'd1);
        frame();
        chk_all("boom", 1'b0, 1'b1, 8'd15);
        chk_pos("boom", 8, 4, 272, 176);
        repeat (14) frame();
        chk_all("blast14", 1'b0, 1'b1, 8'd1);
        frame();
        chk_all("cool", 1'b0, 1'b0, 8'd6);
        repeat (6) frame();
        chk_all("back_idle", 1'b0, 1'b0, 8'd0);

        playerTopLeftX = -11'sd20; playerTopLeftY = 11'd600;
        drop_pulse();
        chk_all("arm_clamp", 1'b1, 1'b0, 8'd90);
        chk_pos("arm_clamp", 0, 12, 16, 432);

        repeat (39) frame();
        chk_all("fuse39", 1'b1, 1'b0, 8'd51);
        startOfFrame = 1'b1; detonate = 1'b1;
        tick();
        startOfFrame = 1'b0; detonate = 1'b0;
        chk_all("detonate_sof", 1'b0, 1'b1, 8'd15);
        repeat (3) frame();
        chk("blast_mid.fuse", 32'(fuseLeft), 32'd12);
        detonate = 1'b1;
        tick();
        detonate = 1'b0;
        chk_all("det_in_blast", 1'b0, 1'b1, 8'd12);

        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        chk_all("mid_reset", 1'b0, 1'b0, 8'd0);
        chk_pos("mid_reset", 0, 0, 0, 0);
        tick();
        chk("post_reset.expl", 32'(exploding), 32'd0);

        playerTopLeftX = 11'd280; playerTopLeftY = 11'd185;
        drop_pulse();
        chk_all("rearm", 1'b1, 1'b0, 8'd90);
        chk_pos("rearm", 8, 4, 272, 176);

        playerTopLeftX = 11'd700; playerTopLeftY = 11'd20;
        drop_bomb = 1'b1;
        tick();
        chk_all("drop_armed", 1'b1, 1'b0, 8'd90);
        chk_pos("drop_armed", 8, 4, 272, 176);
        detonate = 1'b1;
        tick();
        detonate = 1'b0;
        chk_all("det_only", 1'b0, 1'b1, 8'd15);
        repeat (15) frame();
        repeat (6) frame();
        chk_all("held_idle", 1'b0, 1'b0, 8'd0);
        tick(); tick(); tick();
        chk_all("held_noarm", 1'b0, 1'b0, 8'd0);
        drop_bomb = 1'b0;
        tick();
        drop_pulse();
        chk_all("repress", 1'b1, 1'b0, 8'd90);
        chk_pos("repress", 18, 0, 592, 48);

        detonate = 1'b1;
        tick();
        detonate = 1'b0;
        repeat (15) frame();
        repeat (5) frame();
        chk_all("cool_last", 1'b0, 1'b0, 8'd1);
        startOfFrame = 1'b1; drop_bomb = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk_all("drop_at_exit", 1'b0, 1'b0, 8'd0);
        tick();
        chk_all("drop_at_exit_held", 1'b0, 1'b0, 8'd0);
        drop_bomb = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
